// File: rtl/mpq_stim_if.sv
// mpq_stim_if: signal bundle between the host, the mpq_stim sequencer and the MPQ.
//   Host data stream : host_data_valid, host_data[7:0], host_data_last -> host_data_ready
//   Host commands    : host_cmd_valid, host_cmd[2:0], host_index[7:0], host_value[7:0]
//                      -> host_cmd_ready
//   MPQ drive        : mpq_rst, data_valid, data[7:0], cmd_valid, cmd[2:0], index[7:0],
//                      value[7:0]
//   MPQ status       : busy, done
//   Sequence status  : seq_done, cmd_count[7:0]
// Modport slave is the sequencer's view; master is the host/MPQ-side view.
interface mpq_stim_if;
  logic       host_data_valid;
  logic [7:0] host_data;
  logic       host_data_last;
  logic       host_data_ready;

  logic       host_cmd_valid;
  logic [2:0] host_cmd;
  logic [7:0] host_index;
  logic [7:0] host_value;
  logic       host_cmd_ready;

  logic       mpq_rst;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;

  logic       busy;
  logic       done;

  logic       seq_done;
  logic [7:0] cmd_count;

  modport slave (
    input  host_data_valid, host_data, host_data_last,
    output host_data_ready,
    input  host_cmd_valid, host_cmd, host_index, host_value,
    output host_cmd_ready,
    output mpq_rst, data_valid, data, cmd_valid, cmd, index, value,
    input  busy, done,
    output seq_done, cmd_count
  );

  modport master (
    output host_data_valid, host_data, host_data_last,
    input  host_data_ready,
    output host_cmd_valid, host_cmd, host_index, host_value,
    input  host_cmd_ready,
    input  mpq_rst, data_valid, data, cmd_valid, cmd, index, value,
    output busy, done,
    input  seq_done, cmd_count
  );
endinterface

// File: rtl/mpq_stim.sv
// mpq_stim: stimulus sequencer for a downstream priority queue (MPQ).
// Collects a host dataset into a local buffer, releases the MPQ from reset while streaming
// the buffer with no gaps, then issues queued host commands one at a time, waiting for the
// MPQ to go idle before each and for done after a terminating command (cmd >= 4).
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   io_bus - mpq_stim_if.slave bundle (host data/command inputs, MPQ drive, status)
// Parameters:
//   DEPTH    - data buffer entries (1..255)
//   CQ_DEPTH - command FIFO entries (power of two)
module mpq_stim #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned CQ_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  mpq_stim_if.slave io_bus
);

  localparam int unsigned BufAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CqAw  = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
  localparam int unsigned CqCw  = $clog2(CQ_DEPTH + 1);
  localparam logic [7:0]      DepthW = 8'(DEPTH);
  localparam logic [CqAw-1:0] CqLast = CqAw'(CQ_DEPTH - 1);
  localparam logic [CqCw-1:0] CqFull = CqCw'(CQ_DEPTH);

  typedef enum logic [2:0] {
    StCollect, StLaunch, StStream, StGuard, StCmd, StHold, StWaitDone, StFinish
  } state_e;

  state_e r_state, w_state_next;

  logic [7:0] r_buf [DEPTH];
  logic [7:0] r_cnt, r_rd;
  logic       r_mpq_rst, r_data_valid, r_cmd_valid, r_seq_done;
  logic [7:0] r_data, r_index, r_value, r_cmd_count;
  logic [2:0] r_cmd;

  logic [18:0]     r_cq_mem [CQ_DEPTH];
  logic [CqAw-1:0] r_cq_wr, r_cq_rd;
  logic [CqCw-1:0] r_cq_cnt;

  logic        w_data_ready, w_byte_acc, w_push, w_pop, w_cq_empty, w_cq_full;
  logic [18:0] w_cq_head;

  assign w_data_ready = (r_state == StCollect) && (r_cnt < DepthW);
  assign w_byte_acc   = io_bus.host_data_valid && w_data_ready;
  assign w_cq_empty   = (r_cq_cnt == '0);
  assign w_cq_full    = (r_cq_cnt == CqFull);
  assign w_push       = io_bus.host_cmd_valid && !w_cq_full;
  assign w_cq_head    = r_cq_mem[r_cq_rd];

  // Next-state decode; w_pop is the only datapath strobe that depends on inputs here.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      StCollect:  if (w_byte_acc && io_bus.host_data_last) w_state_next = StLaunch;
      StLaunch:   w_state_next = StStream;
      StStream:   if (r_rd >= r_cnt) w_state_next = StGuard;
      StGuard:    w_state_next = StCmd;
      StCmd: begin
        if (!w_cq_empty && !io_bus.busy) begin
          w_pop        = 1'b1;
          w_state_next = StHold;
        end
      end
      // HOLD spans the MPQ's registered busy latency before CMD samples busy again.
      StHold:     w_state_next = (r_cmd >= 3'd4) ? StWaitDone : StCmd;
      StWaitDone: if (io_bus.done) w_state_next = StFinish;
      StFinish:   w_state_next = StCollect;
      default:    w_state_next = StCollect;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StCollect;
    else     r_state <= w_state_next;
  end

  // Datapath registers driven by the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_rd         <= '0;
      r_mpq_rst    <= 1'b1;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= '0;
      r_index      <= '0;
      r_value      <= '0;
      r_seq_done   <= 1'b0;
      r_cmd_count  <= '0;
    end else begin
      r_seq_done <= 1'b0;
      unique case (r_state)
        StCollect: if (w_byte_acc) r_cnt <= r_cnt + 8'd1;
        StLaunch: begin
          // First byte lands together with the reset release.
          r_mpq_rst    <= 1'b0;
          r_data       <= r_buf[0];
          r_data_valid <= 1'b1;
          r_rd         <= 8'd1;
        end
        StStream: begin
          if (r_rd < r_cnt) begin
            r_data <= r_buf[r_rd[BufAw-1:0]];
            r_rd   <= r_rd + 8'd1;
          end else begin
            r_data_valid <= 1'b0;
          end
        end
        StCmd: begin
          if (w_pop) begin
            {r_cmd, r_index, r_value} <= w_cq_head;
            r_cmd_valid <= 1'b1;
            r_cmd_count <= r_cmd_count + 8'd1;
          end
        end
        StHold:     r_cmd_valid <= 1'b0;
        StWaitDone: if (io_bus.done) r_seq_done <= 1'b1;
        StFinish: begin
          r_mpq_rst   <= 1'b1;
          r_cnt       <= '0;
          r_rd        <= '0;
          r_cmd_count <= '0;
        end
        default: ;
      endcase
    end
  end

  // Dataset buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_byte_acc) r_buf[r_cnt[BufAw-1:0]] <= io_bus.host_data;
  end

  // Command FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cq_wr  <= '0;
      r_cq_rd  <= '0;
      r_cq_cnt <= '0;
    end else begin
      if (w_push) r_cq_wr <= (r_cq_wr == CqLast) ? '0 : r_cq_wr + 1'b1;
      if (w_pop)  r_cq_rd <= (r_cq_rd == CqLast) ? '0 : r_cq_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cq_cnt <= r_cq_cnt + 1'b1;
        2'b01:   r_cq_cnt <= r_cq_cnt - 1'b1;
        default: r_cq_cnt <= r_cq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_cq_mem[r_cq_wr] <= {io_bus.host_cmd, io_bus.host_index, io_bus.host_value};
  end

  assign io_bus.host_data_ready = w_data_ready;
  assign io_bus.host_cmd_ready  = !w_cq_full;
  assign io_bus.mpq_rst         = r_mpq_rst;
  assign io_bus.data_valid      = r_data_valid;
  assign io_bus.data            = r_data;
  assign io_bus.cmd_valid       = r_cmd_valid;
  assign io_bus.cmd             = r_cmd;
  assign io_bus.index           = r_index;
  assign io_bus.value           = r_value;
  assign io_bus.seq_done        = r_seq_done;
  assign io_bus.cmd_count       = r_cmd_count;

endmodule
